// File: rtl/rv_decode_stage.sv
// RV32I decode / operand-fetch stage: R-type, I-type ALU and LUI feeding the ALU from a one-deep register.
// Optional RV_DECODE_PERF_CNT_EN adds issued_cnt / stall_cnt performance counters.
module rv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     INSTR,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    output logic [6:0]      OPCODE,
    output logic [2:0]      FUNC3,
    output logic [6:0]      FUNC7,
    output logic [XLEN-1:0] OP1,
    output logic [XLEN-1:0] OP2,
    output logic [4:0]      RD,
    output logic            ILLEGAL
`ifdef RV_DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     issued_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    logic [XLEN-1:0] rf [NREGS];

    logic            vld_p1;
    logic [6:0]      opc_p1;
    logic [2:0]      f3_p1;
    logic [6:0]      f7_p1;
    logic [XLEN-1:0] op1_p1;
    logic [XLEN-1:0] op2_p1;
    logic [4:0]      rd_p1;
    logic            ill_p1;
    logic [4:0]      rs1_p1;
    logic [4:0]      rs2_p1;
    logic            use1_p1;
    logic            use2_p1;

    logic [6:0]      opc_p0;
    logic [2:0]      f3_p0;
    logic [4:0]      rs1_p0;
    logic [4:0]      rs2_p0;
    logic [4:0]      rd_p0;
    logic [XLEN-1:0] rs1_val_p0;
    logic [XLEN-1:0] rs2_val_p0;
    logic signed [XLEN-1:0] imm_i_p0;

    logic            d_ill;
    logic [2:0]      d_f3;
    logic [6:0]      d_f7;
    logic [XLEN-1:0] d_op1;
    logic [XLEN-1:0] d_op2;
    logic [4:0]      d_rd;
    logic            d_use1;
    logic            d_use2;

    logic            accept;
    logic            refresh1;
    logic            refresh2;

    // Register read with write-through so a same-cycle writeback is never missed.
    function automatic logic [XLEN-1:0] read_src(input logic [4:0] idx, input logic [XLEN-1:0] stored,
                                                 input logic we, input logic [4:0] wrd,
                                                 input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] val;
        val = stored;
        if (idx == 5'd0)
            val = '0;
        else if (we && (wrd == idx))
            val = wdata;
        return val;
    endfunction

    assign instr_ready = !vld_p1 || ex_ready;
    assign accept      = instr_valid && instr_ready;

    assign opc_p0   = INSTR[6:0];
    assign f3_p0    = INSTR[14:12];
    assign rd_p0    = INSTR[11:7];
    assign rs1_p0   = INSTR[19:15];
    assign rs2_p0   = INSTR[24:20];
    assign imm_i_p0 = XLEN'($signed(INSTR[31:20]));

    assign rs1_val_p0 = read_src(rs1_p0, rf[rs1_p0], wb_en, wb_rd, wb_data);
    assign rs2_val_p0 = read_src(rs2_p0, rf[rs2_p0], wb_en, wb_rd, wb_data);

    always_comb begin
        d_ill  = 1'b0;
        d_f3   = f3_p0;
        d_f7   = 7'd0;
        d_op1  = '0;
        d_op2  = '0;
        d_rd   = rd_p0;
        d_use1 = 1'b0;
        d_use2 = 1'b0;
        case (opc_p0)
            OPC_R: begin
                d_op1  = rs1_val_p0;
                d_op2  = rs2_val_p0;
                d_f7   = INSTR[31:25];
                d_use1 = 1'b1;
                d_use2 = 1'b1;
            end
            OPC_I: begin
                d_op1  = rs1_val_p0;
                d_use1 = 1'b1;
                if (f3_p0 == 3'b001 || f3_p0 == 3'b101) begin
                    d_f7  = INSTR[31:25];
                    d_op2 = XLEN'(INSTR[24:20]);
                end else begin
                    d_op2 = imm_i_p0;
                end
            end
            OPC_LUI: begin
                d_op2 = XLEN'({INSTR[31:12], 12'b0});
                d_f3  = 3'b000;
            end
            default: begin
                d_ill = 1'b1;
                d_rd  = 5'd0;
            end
        endcase
    end

    // A held instruction tracks writebacks to its source registers until it issues.
    assign refresh1 = vld_p1 && !ex_ready && wb_en && (wb_rd != 5'd0) && use1_p1 && (wb_rd == rs1_p1);
    assign refresh2 = vld_p1 && !ex_ready && wb_en && (wb_rd != 5'd0) && use2_p1 && (wb_rd == rs2_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (wb_en && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Stage p0 -> p1: decoded instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            opc_p1  <= '0;
            f3_p1   <= '0;
            f7_p1   <= '0;
            op1_p1  <= '0;
            op2_p1  <= '0;
            rd_p1   <= '0;
            ill_p1  <= 1'b0;
            rs1_p1  <= '0;
            rs2_p1  <= '0;
            use1_p1 <= 1'b0;
            use2_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            opc_p1  <= opc_p0;
            f3_p1   <= d_f3;
            f7_p1   <= d_f7;
            op1_p1  <= d_op1;
            op2_p1  <= d_op2;
            rd_p1   <= d_rd;
            ill_p1  <= d_ill;
            rs1_p1  <= rs1_p0;
            rs2_p1  <= rs2_p0;
            use1_p1 <= d_use1;
            use2_p1 <= d_use2;
        end else if (vld_p1 && ex_ready) begin
            vld_p1 <= 1'b0;
        end else begin
            if (refresh1)
                op1_p1 <= wb_data;
            if (refresh2)
                op2_p1 <= wb_data;
        end
    end

    assign out_valid = vld_p1;
    assign OPCODE    = opc_p1;
    assign FUNC3     = f3_p1;
    assign FUNC7     = f7_p1;
    assign OP1       = op1_p1;
    assign OP2       = op2_p1;
    assign RD        = rd_p1;
    assign ILLEGAL   = ill_p1;

`ifdef RV_DECODE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (vld_p1 && ex_ready && !flush)
                issued_cnt <= issued_cnt + 32'd1;
            if (vld_p1 && !ex_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// Testbench for rv_decode_stage: directed scenarios plus randomized traffic against an architectural model.
module tb_rv_decode_stage;

    typedef struct packed {
        logic        ill;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] INSTR;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic        ex_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNC3;
    logic [6:0]  FUNC7;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [4:0]  RD;
    logic        ILLEGAL;
`ifdef RV_DECODE_PERF_CNT_EN
    logic [31:0] issued_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mrf [32];
    logic        exp_v;
    logic [31:0] exp_instr;
    logic [31:0] m_issued;
    logic [31:0] m_stall;

    rv_decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .INSTR(INSTR), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .flush(flush), .ex_ready(ex_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .OPCODE(OPCODE), .FUNC3(FUNC3), .FUNC7(FUNC7), .OP1(OP1), .OP2(OP2),
        .RD(RD), .ILLEGAL(ILLEGAL)
`ifdef RV_DECODE_PERF_CNT_EN
        , .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Architectural view: what the ALU should see for an instruction given the current register state.
    function automatic dec_t model_decode(input logic [31:0] ins);
        dec_t d;
        int   imm;
        d.ill = 1'b0; d.opc = ins[6:0]; d.f3 = ins[14:12]; d.f7 = 7'd0;
        d.op1 = 32'd0; d.op2 = 32'd0; d.rd = ins[11:7];
        if (ins[6:0] == 7'h33) begin
            d.op1 = mrf[ins[19:15]];
            d.op2 = mrf[ins[24:20]];
            d.f7  = ins[31:25];
        end else if (ins[6:0] == 7'h13) begin
            d.op1 = mrf[ins[19:15]];
            if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
                d.f7  = ins[31:25];
                d.op2 = 32'(ins[24:20]);
            end else begin
                imm = int'(ins[31:20]);
                if (imm >= 2048) imm = imm - 4096;
                d.op2 = imm;
            end
        end else if (ins[6:0] == 7'h37) begin
            d.op2 = 32'(ins[31:12]) * 32'd4096;
            d.f3  = 3'd0;
        end else begin
            d.ill = 1'b1;
            d.rd  = 5'd0;
        end
        return d;
    endfunction

    function automatic dec_t dut_dec();
        dec_t d;
        d.ill = ILLEGAL; d.opc = OPCODE; d.f3 = FUNC3; d.f7 = FUNC7;
        d.op1 = OP1; d.op2 = OP2; d.rd = RD;
        return d;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] ins, input logic fl, input logic exr,
                          input logic we, input logic [4:0] wr, input logic [31:0] wd);
        instr_valid = v; INSTR = ins; flush = fl; ex_ready = exr;
        wb_en = we; wb_rd = wr; wb_data = wd;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        exp_v = 1'b0; exp_instr = 32'd0; m_issued = 32'd0; m_stall = 32'd0;
    endtask

    // Advance one clock edge, moving the model state along with the current inputs.
    task automatic tick();
        logic rdy;
        rdy = !exp_v || ex_ready;
        if (exp_v && ex_ready && !flush) m_issued = m_issued + 32'd1;
        if (exp_v && !ex_ready) m_stall = m_stall + 32'd1;
        if (flush) exp_v = 1'b0;
        else if (instr_valid && rdy) begin exp_v = 1'b1; exp_instr = INSTR; end
        else if (ex_ready) exp_v = 1'b0;
        if (wb_en && wb_rd != 5'd0) mrf[wb_rd] = wb_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, ILLEGAL, OPCODE, FUNC3, FUNC7, OP1, OP2, RD} !== '0) begin
            errors++; $display("FAIL reset_outputs got v=%b ill=%b op1=%h op2=%h rd=%0d exp all zero",
                               out_valid, ILLEGAL, OP1, OP2, RD);
        end
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", instr_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        set_in(0, 32'd0, 0, 1, 1, 5'd1, 32'd10); tick();
        set_in(0, 32'd0, 0, 1, 1, 5'd2, 32'd20); tick();
        set_in(1, 32'h002081B3, 0, 1, 0, 5'd0, 32'd0);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b exp 1", instr_ready); end
        tick();
        set_in(0, 32'd0, 0, 1, 0, 5'd0, 32'd0);
        checks++;
        if ({out_valid, ILLEGAL, OPCODE, FUNC3, FUNC7, OP1, OP2, RD} !==
            {1'b1, 1'b0, 7'b0110011, 3'd0, 7'd0, 32'd10, 32'd20, 5'd3}) begin
            errors++; $display("FAIL add_issue got v=%b opc=%b f3=%0d f7=%b op1=%0d op2=%0d rd=%0d exp v=1 opc=0110011 f3=0 f7=0 op1=10 op2=20 rd=3",
                               out_valid, OPCODE, FUNC3, FUNC7, OP1, OP2, RD);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_addi();
        set_in(0, 32'd0, 0, 1, 1, 5'd1, 32'hFF00FF00); tick();
        set_in(1, 32'hFFF08093, 0, 1, 0, 5'd0, 32'd0); tick();
        checks++;
        if ({OP1, OP2, FUNC7, FUNC3, RD, ILLEGAL} !== {32'hFF00FF00, 32'hFFFFFFFF, 7'd0, 3'd0, 5'd1, 1'b0}) begin
            errors++; $display("FAIL addi_neg got op1=%h op2=%h f7=%b rd=%0d exp op1=ff00ff00 op2=ffffffff f7=0 rd=1",
                               OP1, OP2, FUNC7, RD);
        end
        set_in(1, 32'h00509213, 0, 1, 0, 5'd0, 32'd0); tick();
        checks++;
        if ({FUNC3, FUNC7, OP2, RD} !== {3'b001, 7'd0, 32'd5, 5'd4}) begin
            errors++; $display("FAIL slli got f3=%b f7=%b op2=%h rd=%0d exp f3=001 f7=0 op2=5 rd=4", FUNC3, FUNC7, OP2, RD);
        end
        set_in(1, 32'h4030D213, 0, 1, 0, 5'd0, 32'd0); tick();
        checks++;
        if ({FUNC3, FUNC7, OP1, OP2} !== {3'b101, 7'b0100000, 32'hFF00FF00, 32'd3}) begin
            errors++; $display("FAIL srai got f3=%b f7=%b op1=%h op2=%h exp f3=101 f7=0100000 op1=ff00ff00 op2=3",
                               FUNC3, FUNC7, OP1, OP2);
        end
        set_in(0, 32'd0, 0, 1, 0, 5'd0, 32'd0); tick();
    endtask

    task automatic test_bypass();
        set_in(1, 32'h400302B3, 0, 1, 1, 5'd6, 32'h1234); tick();
        set_in(0, 32'd0, 0, 1, 0, 5'd0, 32'd0);
        checks++;
        if ({out_valid, OP1, OP2, FUNC7, RD} !== {1'b1, 32'h1234, 32'd0, 7'b0100000, 5'd5}) begin
            errors++; $display("FAIL bypass got v=%b op1=%h op2=%h f7=%b rd=%0d exp v=1 op1=1234 op2=0 f7=0100000 rd=5",
                               out_valid, OP1, OP2, FUNC7, RD);
        end
        tick();
    endtask

    task automatic test_stall_refresh();
        dec_t snap;
        dec_t want;
        set_in(1, 32'h002081B3, 0, 1, 0, 5'd0, 32'd0); tick();
        snap = dut_dec();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'hFFF08093, 0, 0, (k == 2), 5'd1, 32'd7);
            #1;
            checks++;
            if (instr_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc%0d got %b exp 0", k, instr_ready); end
            checks++;
            if (dut_dec() !== snap || out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold cyc%0d got op1=%h op2=%h rd=%0d exp op1=%h op2=%h rd=%0d",
                                   k, OP1, OP2, RD, snap.op1, snap.op2, snap.rd);
            end
            tick();
        end
        want = snap;
        want.op1 = 32'd7;
        checks++;
        if (dut_dec() !== want || out_valid !== 1'b1) begin
            errors++; $display("FAIL refresh got op1=%h op2=%h rd=%0d exp op1=7 op2=%h rd=%0d",
                               OP1, OP2, RD, want.op2, want.rd);
        end
        set_in(1, 32'hFFF08093, 0, 1, 0, 5'd0, 32'd0);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", instr_ready); end
        tick();
        checks++;
        if ({out_valid, OP1, OP2, RD} !== {1'b1, 32'd7, 32'hFFFFFFFF, 5'd1}) begin
            errors++; $display("FAIL after_stall got v=%b op1=%h op2=%h rd=%0d exp v=1 op1=7 op2=ffffffff rd=1",
                               out_valid, OP1, OP2, RD);
        end
        set_in(0, 32'd0, 0, 1, 0, 5'd0, 32'd0); tick();
    endtask

    task automatic test_flush_illegal();
        set_in(1, 32'h002081B3, 0, 1, 0, 5'd0, 32'd0); tick();
        set_in(1, 32'h002081B3, 1, 1, 0, 5'd0, 32'd0); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept got v=%b exp 0", out_valid); end
        set_in(1, 32'h002081B3, 0, 0, 0, 5'd0, 32'd0); tick();
        set_in(0, 32'd0, 1, 0, 0, 5'd0, 32'd0); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held got v=%b exp 0", out_valid); end
        set_in(1, 32'h00000003, 0, 1, 0, 5'd0, 32'd0); tick();
        set_in(0, 32'd0, 0, 1, 0, 5'd0, 32'd0);
        checks++;
        if ({out_valid, ILLEGAL, OP1, OP2, FUNC7, RD, OPCODE} !== {1'b1, 1'b1, 32'd0, 32'd0, 7'd0, 5'd0, 7'b0000011}) begin
            errors++; $display("FAIL illegal got v=%b ill=%b op1=%h op2=%h f7=%b rd=%0d exp v=1 ill=1 op1=0 op2=0 f7=0 rd=0",
                               out_valid, ILLEGAL, OP1, OP2, FUNC7, RD);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        for (int k = 1; k <= 4; k++) begin
            ins = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
            set_in(1, ins, 0, 1, 0, 5'd0, 32'd0);
            tick();
            checks++;
            if ({out_valid, OP1, OP2, RD} !== {1'b1, 32'd0, 32'(k), 5'(k)}) begin
                errors++; $display("FAIL b2b_%0d got v=%b op1=%h op2=%h rd=%0d exp v=1 op1=0 op2=%0d rd=%0d",
                                   k, out_valid, OP1, OP2, RD, k, k);
            end
        end
        set_in(0, 32'd0, 0, 1, 0, 5'd0, 32'd0); tick();
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [6:0]  ill_opc [6];
        dec_t        want;
        ill_opc[0] = 7'h03; ill_opc[1] = 7'h23; ill_opc[2] = 7'h63;
        ill_opc[3] = 7'h6F; ill_opc[4] = 7'h17; ill_opc[5] = 7'h00;
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ins[6:0] = 7'h33;
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h37;
                default: ins[6:0] = ill_opc[$urandom_range(0, 5)];
            endcase
            set_in(($urandom_range(0, 9) < 7), ins, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
                   ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom);
            #1;
            checks++;
            if (instr_ready !== (!exp_v || ex_ready)) begin
                errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, instr_ready, !exp_v || ex_ready);
            end
            checks++;
            if (out_valid !== exp_v) begin
                errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, out_valid, exp_v);
            end
            if (exp_v && ex_ready) begin
                want = model_decode(exp_instr);
                checks++;
                if (dut_dec() !== want) begin
                    errors++; $display("FAIL rnd_issue n=%0d instr=%h got ill=%b f3=%0d f7=%b op1=%h op2=%h rd=%0d exp ill=%b f3=%0d f7=%b op1=%h op2=%h rd=%0d",
                                       n, exp_instr, ILLEGAL, FUNC3, FUNC7, OP1, OP2, RD,
                                       want.ill, want.f3, want.f7, want.op1, want.op2, want.rd);
                end
            end
            tick();
        end
        set_in(0, 32'd0, 0, 1, 0, 5'd0, 32'd0); tick();
`ifdef RV_DECODE_PERF_CNT_EN
        checks++;
        if (issued_cnt !== m_issued || stall_cnt !== m_stall) begin
            errors++; $display("FAIL perf_cnt got issued=%0d stall=%0d exp issued=%0d stall=%0d",
                               issued_cnt, stall_cnt, m_issued, m_stall);
        end
`endif
    endtask

    task automatic test_async_reset();
        set_in(0, 32'd0, 0, 1, 1, 5'd1, 32'd55); tick();
        set_in(1, 32'h002081B3, 0, 1, 0, 5'd0, 32'd0); tick();
        set_in(0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
        #2;
        checks++;
        if (out_valid !== 1'b1 || OP1 !== 32'd55) begin
            errors++; $display("FAIL areset_pre got v=%b op1=%h exp v=1 op1=37", out_valid, OP1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || OP1 !== 32'd0 || RD !== 5'd0) begin
            errors++; $display("FAIL areset_now got v=%b op1=%h rd=%0d exp v=0 op1=0 rd=0", out_valid, OP1, RD);
        end
`ifdef RV_DECODE_PERF_CNT_EN
        checks++;
        if (issued_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL areset_cnt got issued=%0d stall=%0d exp 0 0", issued_cnt, stall_cnt);
        end
`endif
        #1;
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        set_in(1, 32'h002081B3, 0, 1, 0, 5'd0, 32'd0); tick();
        checks++;
        if ({out_valid, OP1, OP2, RD} !== {1'b1, 32'd0, 32'd0, 5'd3}) begin
            errors++; $display("FAIL areset_after got v=%b op1=%h op2=%h rd=%0d exp v=1 op1=0 op2=0 rd=3",
                               out_valid, OP1, OP2, RD);
        end
        set_in(0, 32'd0, 0, 1, 0, 5'd0, 32'd0); tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_bypass();
        test_stall_refresh();
        test_flush_illegal();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU.
- Accepts a 32-bit RV32I instruction through a valid/ready handshake and reads a 32x32 register file with one writeback port.
- Drives the ALU's OPCODE, FUNC3, FUNC7, OP1 and OP2 from a one-deep pipeline register.
- Covers R-type, I-type ALU and LUI. Every other opcode is flagged illegal.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- NREGS, 32, register file depth; x0 is hardwired to zero

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- INSTR  in  32  instruction word
- instr_valid  in  1  INSTR is valid
- instr_ready  out  1  stage can accept INSTR this cycle
- flush  in  1  synchronous kill of the held instruction
- ex_ready  in  1  ALU stage consumes the outputs this cycle
- wb_en  in  1  register file write enable
- wb_rd  in  5  writeback destination index
- wb_data  in  32  writeback data
- out_valid  out  1  outputs hold a decoded instruction
- OPCODE  out  7  INSTR[6:0]
- FUNC3  out  3  INSTR[14:12]
- FUNC7  out  7  ALU function-7 field
- OP1  out  32  ALU operand 1
- OP2  out  32  ALU operand 2
- RD  out  5  destination index, passed downstream
- ILLEGAL  out  1  unsupported opcode

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, ILLEGAL, OPCODE, FUNC3, FUNC7, OP1, OP2 and RD go to 0.
  - All register file entries go to 0.
- Stage state: EMPTY (out_valid=0) or FULL (out_valid=1).
- instr_ready = !out_valid || ex_ready. This is combinational and never depends on instr_valid.
- Accept = instr_valid && instr_ready. On accept, decoded outputs are registered. Latency is 1 cycle from accept to out_valid.
- Transitions:
  - FULL with ex_ready and no accept -> EMPTY.
  - FULL with ex_ready and accept -> FULL with the new instruction (back-to-back, 1 instruction per cycle).
- Hold: when FULL and !ex_ready, all outputs are stable, except for the operand refresh below.
- Flush: clears out_valid on the next edge and takes priority over accept. An instruction presented in the same cycle as flush is dropped. instr_ready is still computed as above.
- Register file:
  - Written on the clock edge when wb_en=1 and wb_rd!=0.
  - Writes to x0 are ignored, and x0 always reads 0.
- Write-through bypass at capture: if wb_en && wb_rd==rs && rs!=0 in the accept cycle, the operand takes wb_data.
- Operand refresh while held: if FULL, !ex_ready, wb_en, wb_rd!=0 and wb_rd matches the held rs1 (or rs2 when OP2 is register-sourced), the matching OP is overwritten with wb_data on that edge.
- Decode for R-type, OPCODE 0110011:
  - OP1 = x[rs1], OP2 = x[rs2].
  - FUNC7 = INSTR[31:25].
- Decode for I-type ALU, OPCODE 0010011:
  - OP1 = x[rs1], OP2 = sign-extended INSTR[31:20].
  - FUNC7 = INSTR[31:25] when FUNC3 is 001 or 101 (shifts), otherwise 0000000.
  - For shifts, OP2 = zero-extended INSTR[24:20].
- Decode for LUI, OPCODE 0110111:
  - OP1 = 0, OP2 = {INSTR[31:12], 12'b0}.
  - FUNC7 = 0, FUNC3 = 000.
- Any other opcode:
  - ILLEGAL = 1, OP1 = OP2 = 0, FUNC7 = 0.
  - out_valid still asserts and RD = 0.
- RD = INSTR[11:7] for supported opcodes.
- Reset mid-operation: any held instruction is lost and the stage restarts EMPTY.

Optional Feature:
- Macro: RV_DECODE_PERF_CNT_EN.
- When defined:
  - Adds output issued_cnt (32 bits), which increments on every cycle with out_valid && ex_ready && !flush.
  - Adds output stall_cnt (32 bits), which increments on every cycle with out_valid && !ex_ready.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Basic ADD issue:
  - Stimulus: preload x1=10, x2=20 via wb, then INSTR=0x002081B3 (add x3,x1,x2) with ex_ready=1.
  - Response: next cycle out_valid=1, OPCODE=0110011, FUNC3=000, FUNC7=0, OP1=10, OP2=20, RD=3.
- ADDI with negative immediate:
  - Stimulus: INSTR=0xFFF08093 (addi x1,x1,-1).
  - Response: OP2=0xFFFFFFFF, FUNC7=0. With x1=0xFF00FF00, OP1=0xFF00FF00.
- Bypass and x0:
  - Stimulus: in the accept cycle of sub x5,x6,x0 (0x400302B3), drive wb_en=1, wb_rd=6, wb_data=0x1234.
  - Response: OP1=0x1234, OP2=0, FUNC7=0100000.
- Stall and refresh:
  - Stimulus: hold ex_ready=0 for 3 cycles with a new instruction pending, then write x1=7 while held.
  - Response: instr_ready=0 throughout, outputs unchanged except OP1 becomes 7; instruction issues on ex_ready=1.
- Flush priority and illegal:
  - Stimulus: assert flush together with instr_valid.
  - Response: out_valid=0 next cycle.
  - Stimulus: present INSTR=0x00000003 (load).
  - Response: ILLEGAL=1, OP1=OP2=0, out_valid=1.
- Asynchronous reset:
  - Stimulus: drop rst_n mid-cycle while FULL.
  - Response: out_valid=0 immediately, x1 reads 0 after release, and counters are 0 when the macro is defined.
